// File: rtl/pdm_capture_pkg.sv
// pdm_capture_pkg: shared state encoding and default sizes for the PDM capture buffer
package pdm_capture_pkg;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_READOUT = 2'd3
   } state_t;
   localparam int DEF_DATA_W = 7;
   localparam int DEF_DEPTH  = 1024;
endpackage

// File: rtl/pdm_capture_ram.sv
// pdm_capture_ram: simple dual-port sample store, one write port and one registered read port
module pdm_capture_ram #(
   parameter int DATA_W = 7,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              CLK_IN,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];
   // write port and synchronous read, no reset so the array maps onto block RAM
   always_ff @(posedge CLK_IN) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/pdm_capture_buffer.sv
// pdm_capture_buffer: threshold-triggered burst capture of amplitude samples with AXI-stream style replay
module pdm_capture_buffer
   import pdm_capture_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              CLK_IN,
   input  logic              RST_IN,
   input  logic [DATA_W-1:0] AMP_IN,
   input  logic              AMP_VALID_IN,
   input  logic              ARM_IN,
   input  logic              FORCE_TRIG_IN,
   input  logic [DATA_W-1:0] THRESHOLD_IN,
   output logic [DATA_W-1:0] M_TDATA,
   output logic              M_TVALID,
   input  logic              M_TREADY,
   output logic              M_TLAST,
   output logic [1:0]        STATE_OUT,
   output logic              DONE_OUT
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state, state_d;
   logic [ADDR_W-1:0] wr_cnt, rd_addr;
   logic              rd_all, rd_pend, rd_pend_last;
   logic              out_v, out_l, sk_v, sk_l, done;
   logic [DATA_W-1:0] out_d, sk_d, ram_q;
   logic              trig, wr_en, cap_end, pop, fin, rd_en;
   logic [1:0]        occ;

   // trigger, write enable, handshake and read-issue decisions
   always_comb begin
      trig    = FORCE_TRIG_IN || (AMP_VALID_IN && AMP_IN >= THRESHOLD_IN);
      wr_en   = AMP_VALID_IN && (state == ST_CAPTURE || (state == ST_ARMED && trig));
      cap_end = state == ST_CAPTURE && AMP_VALID_IN && wr_cnt == LAST_ADDR;
      pop     = out_v && M_TREADY;
      fin     = state == ST_READOUT && pop && out_l && !ARM_IN;
      occ     = 2'(out_v) + 2'(sk_v) + 2'(rd_pend) - 2'(pop);
      rd_en   = state == ST_READOUT && !ARM_IN && !rd_all && occ < 2'd2;
   end

   // next-state selection
   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:    state_d = ARM_IN ? ST_ARMED : ST_IDLE;
         ST_ARMED:   state_d = trig ? ST_CAPTURE : ST_ARMED;
         ST_CAPTURE: state_d = cap_end ? ST_READOUT : ST_CAPTURE;
         ST_READOUT: state_d = ARM_IN ? ST_ARMED : (fin ? ST_IDLE : ST_READOUT);
         default:    state_d = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) state <= ST_IDLE;
      else        state <= state_d;
   end

   // write counter, read pointer and the two-entry prefetch/skid output stage
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         wr_cnt       <= '0;
         rd_addr      <= '0;
         rd_all       <= 1'b0;
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
         out_v        <= 1'b0;
         out_l        <= 1'b0;
         out_d        <= '0;
         sk_v         <= 1'b0;
         sk_l         <= 1'b0;
         sk_d         <= '0;
         done         <= 1'b0;
      end else begin
         done   <= fin;
         wr_cnt <= wr_en ? wr_cnt + ADDR_W'(1) : (state == ST_CAPTURE ? wr_cnt : '0);
         if (state != ST_READOUT || ARM_IN) begin
            rd_addr      <= '0;
            rd_all       <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            out_v        <= 1'b0;
            out_l        <= 1'b0;
            sk_v         <= 1'b0;
            sk_l         <= 1'b0;
         end else begin
            rd_pend      <= rd_en;
            rd_pend_last <= rd_en && rd_addr == LAST_ADDR;
            if (rd_en) begin
               rd_addr <= rd_addr + ADDR_W'(1);
               rd_all  <= rd_addr == LAST_ADDR;
            end
            if (!out_v || pop) begin
               if (sk_v) begin
                  out_v <= 1'b1;
                  out_d <= sk_d;
                  out_l <= sk_l;
                  sk_v  <= rd_pend;
                  sk_d  <= ram_q;
                  sk_l  <= rd_pend_last;
               end else begin
                  out_v <= rd_pend;
                  out_d <= rd_pend ? ram_q : out_d;
                  out_l <= rd_pend_last;
               end
            end else if (rd_pend) begin
               sk_v <= 1'b1;
               sk_d <= ram_q;
               sk_l <= rd_pend_last;
            end
         end
      end
   end

   pdm_capture_ram #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .CLK_IN (CLK_IN),
      .wr_en  (wr_en),
      .wr_addr(wr_cnt),
      .wr_data(AMP_IN),
      .rd_en  (rd_en),
      .rd_addr(rd_addr),
      .rd_data(ram_q)
   );

   assign M_TDATA   = out_d;
   assign M_TVALID  = out_v;
   assign M_TLAST   = out_v && out_l;
   assign STATE_OUT = state;
   assign DONE_OUT  = done;
endmodule

// File: tb/tb_pdm_capture_buffer.sv
// tb_pdm_capture_buffer: directed vector and sequence checks of the capture buffer at DEPTH 8
module tb_pdm_capture_buffer;
   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [6:0] amp = '0;
   logic       vld = 1'b0, arm = 1'b0, frc = 1'b0, rdy = 1'b1;
   logic [6:0] thr = 7'd40;
   logic [6:0] m_tdata;
   logic       m_tvalid, m_tlast, done_out;
   logic [1:0] state_out;
   int         total = 0, bad = 0;
   logic [6:0] exp_q [8];

   typedef struct {
      logic [6:0] amp;
      logic       vld, arm, frc, rdy;
      logic [1:0] st;
      logic       tv;
      logic [6:0] td;
      logic       tl, dn;
   } vec_t;
   vec_t tbl [23];

   pdm_capture_buffer #(.DATA_W(7), .DEPTH(8)) dut (
      .CLK_IN       (clk_in),
      .RST_IN       (rst_in),
      .AMP_IN       (amp),
      .AMP_VALID_IN (vld),
      .ARM_IN       (arm),
      .FORCE_TRIG_IN(frc),
      .THRESHOLD_IN (thr),
      .M_TDATA      (m_tdata),
      .M_TVALID     (m_tvalid),
      .M_TREADY     (rdy),
      .M_TLAST      (m_tlast),
      .STATE_OUT    (state_out),
      .DONE_OUT     (done_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk_in);
   endtask

   task automatic feed(input logic [6:0] v, input int gap);
      amp = v;
      vld = 1'b1;
      cyc();
      vld = 1'b0;
      repeat (gap) cyc();
   endtask

   task automatic do_arm();
      arm = 1'b1;
      cyc();
      arm = 1'b0;
   endtask

   task automatic set_ramp(input logic [6:0] b);
      for (int i = 0; i < 8; i++) exp_q[i] = b + 7'(i);
   endtask

   task automatic drain(input bit rnd);
      int         cnt = 0;
      int         guard = 0;
      logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
      logic [6:0] pd = '0;
      while (cnt < 8 && guard < 300) begin
         if (pv && !pr) chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, pl, pd});
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_tvalid && rdy) begin
            chk($sformatf("beat%0d_data", cnt), m_tdata, exp_q[cnt]);
            chk($sformatf("beat%0d_last", cnt), m_tlast, cnt == 7);
            cnt++;
         end
         pv = m_tvalid;
         pr = rdy;
         pd = m_tdata;
         pl = m_tlast;
         cyc();
         guard++;
      end
      chk("beat_count", cnt, 8);
      chk("done_pulse", done_out, 1);
      chk("end_state", state_out, 0);
      chk("end_valid", m_tvalid, 0);
      rdy = 1'b1;
      cyc();
      chk("done_once", done_out, 0);
   endtask

   initial begin
      tbl[0]  = '{7'd99,  1, 1, 0, 1, 2'd1, 0, 7'd0,  0, 0};
      tbl[1]  = '{7'd100, 0, 0, 0, 1, 2'd1, 0, 7'd0,  0, 0};
      tbl[2]  = '{7'd10,  1, 0, 0, 1, 2'd1, 0, 7'd0,  0, 0};
      tbl[3]  = '{7'd20,  1, 0, 0, 1, 2'd1, 0, 7'd0,  0, 0};
      tbl[4]  = '{7'd50,  1, 0, 0, 1, 2'd2, 0, 7'd0,  0, 0};
      tbl[5]  = '{7'd60,  1, 0, 0, 1, 2'd2, 0, 7'd0,  0, 0};
      tbl[6]  = '{7'd61,  1, 0, 0, 1, 2'd2, 0, 7'd0,  0, 0};
      tbl[7]  = '{7'd62,  1, 0, 0, 1, 2'd2, 0, 7'd0,  0, 0};
      tbl[8]  = '{7'd63,  1, 0, 0, 1, 2'd2, 0, 7'd0,  0, 0};
      tbl[9]  = '{7'd64,  1, 0, 0, 1, 2'd2, 0, 7'd0,  0, 0};
      tbl[10] = '{7'd65,  1, 0, 0, 1, 2'd2, 0, 7'd0,  0, 0};
      tbl[11] = '{7'd66,  1, 0, 0, 1, 2'd3, 0, 7'd0,  0, 0};
      tbl[12] = '{7'd0,   0, 0, 0, 1, 2'd3, 0, 7'd0,  0, 0};
      tbl[13] = '{7'd0,   0, 0, 0, 1, 2'd3, 1, 7'd50, 0, 0};
      tbl[14] = '{7'd0,   0, 0, 0, 1, 2'd3, 1, 7'd60, 0, 0};
      tbl[15] = '{7'd0,   0, 0, 0, 1, 2'd3, 1, 7'd61, 0, 0};
      tbl[16] = '{7'd0,   0, 0, 0, 1, 2'd3, 1, 7'd62, 0, 0};
      tbl[17] = '{7'd0,   0, 0, 0, 1, 2'd3, 1, 7'd63, 0, 0};
      tbl[18] = '{7'd0,   0, 0, 0, 1, 2'd3, 1, 7'd64, 0, 0};
      tbl[19] = '{7'd0,   0, 0, 0, 1, 2'd3, 1, 7'd65, 0, 0};
      tbl[20] = '{7'd0,   0, 0, 0, 1, 2'd3, 1, 7'd66, 1, 0};
      tbl[21] = '{7'd0,   0, 0, 0, 1, 2'd0, 0, 7'd0,  0, 1};
      tbl[22] = '{7'd0,   0, 0, 0, 1, 2'd0, 0, 7'd0,  0, 0};

      cyc();
      chk("rst_state", state_out, 0);
      chk("rst_valid", m_tvalid, 0);
      chk("rst_last", m_tlast, 0);
      chk("rst_done", done_out, 0);
      chk("rst_data", m_tdata, 0);
      rst_in = 1'b0;
      cyc();

      // threshold trigger with a ramp, full-rate replay
      for (int i = 0; i < 23; i++) begin
         amp = tbl[i].amp;
         vld = tbl[i].vld;
         arm = tbl[i].arm;
         frc = tbl[i].frc;
         rdy = tbl[i].rdy;
         cyc();
         chk($sformatf("row%0d_state", i), state_out, tbl[i].st);
         chk($sformatf("row%0d_valid", i), m_tvalid, tbl[i].tv);
         chk($sformatf("row%0d_last", i), m_tlast, tbl[i].tl);
         chk($sformatf("row%0d_done", i), done_out, tbl[i].dn);
         if (tbl[i].tv) chk($sformatf("row%0d_data", i), m_tdata, tbl[i].td);
      end
      arm = 1'b0;
      vld = 1'b0;

      // forced trigger, zeros with gaps, first-valid latency
      do_arm();
      chk("frc_armed", state_out, 1);
      frc = 1'b1;
      cyc();
      frc = 1'b0;
      chk("frc_capture", state_out, 2);
      for (int i = 0; i < 7; i++) feed(7'd0, i % 3);
      chk("frc_before_last", state_out, 2);
      feed(7'd0, 0);
      chk("frc_readout", state_out, 3);
      chk("frc_lat0", m_tvalid, 0);
      cyc();
      chk("frc_lat1", m_tvalid, 0);
      cyc();
      chk("frc_lat2", m_tvalid, 1);
      for (int i = 0; i < 8; i++) exp_q[i] = 7'd0;
      drain(1'b0);

      // random backpressure
      do_arm();
      for (int i = 0; i < 8; i++) feed(7'd45 + 7'(i), i % 2);
      set_ramp(7'd45);
      drain(1'b1);

      // abort replay with ARM after three beats, then fresh capture
      do_arm();
      for (int i = 0; i < 8; i++) feed(7'd70 + 7'(i), 0);
      rdy = 1'b1;
      cyc();
      cyc();
      chk("abort_first", m_tdata, 70);
      cyc();
      cyc();
      cyc();
      chk("abort_fourth", m_tdata, 73);
      rdy = 1'b0;
      arm = 1'b1;
      cyc();
      arm = 1'b0;
      chk("abort_valid", m_tvalid, 0);
      chk("abort_state", state_out, 1);
      chk("abort_done", done_out, 0);
      cyc();
      chk("abort_done2", done_out, 0);
      rdy = 1'b1;
      for (int i = 0; i < 8; i++) feed(7'd80 + 7'(i), 0);
      set_ramp(7'd80);
      drain(1'b0);

      // reset in the middle of a capture, then a clean full burst
      do_arm();
      for (int i = 0; i < 4; i++) feed(7'd90 + 7'(i), 0);
      chk("mid_capture", state_out, 2);
      rst_in = 1'b1;
      #1;
      chk("async_rst_state", state_out, 0);
      chk("async_rst_data", m_tdata, 0);
      cyc();
      rst_in = 1'b0;
      cyc();
      do_arm();
      for (int i = 0; i < 7; i++) feed(7'd41 + 7'(i), 0);
      chk("no_stale_cnt", state_out, 2);
      feed(7'd48, 0);
      chk("full_burst", state_out, 3);
      set_ramp(7'd41);
      drain(1'b0);

      // reset while a beat is presented
      do_arm();
      for (int i = 0; i < 8; i++) feed(7'd100 + 7'(i), 0);
      rdy = 1'b0;
      cyc();
      cyc();
      chk("pre_rst_valid", m_tvalid, 1);
      rst_in = 1'b1;
      #1;
      chk("async_rst_valid", m_tvalid, 0);
      chk("async_rst_state2", state_out, 0);
      cyc();
      rst_in = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pdm_capture_buffer.md
Name: pdm_capture_buffer

Overview:
- Sits directly downstream of the PDM amplitude stage.
- Consumes its 7-bit amplitude samples and their valid strobe.
- Waits, once armed, for an amplitude at or above a programmable threshold (or a forced trigger), then stores a fixed-length burst of consecutive samples in on-chip RAM.
- Replays the stored burst on a valid/ready stream with a last marker, for a DMA/PS reader or a UART dumper.

Parameters:
- DATA_W, 7, amplitude sample width; must match the upstream amplitude width.
- DEPTH, 1024, samples per capture; power of two, 2..65536. Internal ADDR_W = $clog2(DEPTH).

Ports:
- CLK_IN  in  1  system clock, same domain as the upstream amplitude stage.
- RST_IN  in  1  asynchronous, active-high reset.
- AMP_IN  in  DATA_W  amplitude sample from the upstream stage.
- AMP_VALID_IN  in  1  single-cycle strobe qualifying AMP_IN.
- ARM_IN  in  1  pulse; arms a new capture.
- FORCE_TRIG_IN  in  1  pulse; triggers immediately when ARMED.
- THRESHOLD_IN  in  DATA_W  trigger level, compared unsigned; must be quasi-static while ARMED.
- M_TDATA  out  DATA_W  replayed sample.
- M_TVALID  out  1  M_TDATA valid.
- M_TREADY  in  1  downstream accept.
- M_TLAST  out  1  marks sample DEPTH-1 of the burst.
- STATE_OUT  out  2  current state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 READOUT.
- DONE_OUT  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE.
  - M_TVALID, M_TLAST, DONE_OUT = 0; M_TDATA = 0; STATE_OUT = 0.
  - Write and read counters = 0.
  - RAM contents are not reset.
  - Reset mid-capture or mid-readout abandons the burst; M_TVALID drops asynchronously.
- IDLE:
  - ARM_IN = 1 -> ARMED next cycle.
  - Samples are ignored, including one arriving in the same cycle as ARM_IN.
- ARMED: trigger fires in a cycle when AMP_VALID_IN = 1 and AMP_IN >= THRESHOLD_IN, or when FORCE_TRIG_IN = 1.
  - Valid-sample trigger: that sample is written at address 0, wr_cnt = 1, state -> CAPTURE.
  - Forced trigger with no valid sample that cycle: wr_cnt = 0, state -> CAPTURE; the first stored sample is the next valid one.
  - THRESHOLD_IN = 0 triggers on the first valid sample.
  - ARM_IN while ARMED: no effect.
- CAPTURE:
  - Each AMP_VALID_IN writes AMP_IN at wr_cnt, then wr_cnt increments.
  - When the write of sample DEPTH-1 occurs, state -> READOUT next cycle. Exactly DEPTH samples are stored; no wrap, no overwrite.
  - ARM_IN and FORCE_TRIG_IN are ignored.
  - Valid gaps of any length are tolerated.
- READOUT:
  - RAM has synchronous read, 1-cycle latency.
  - A two-entry output stage (prefetch + skid) gives the timing:
    - first M_TVALID asserts exactly 2 cycles after entering READOUT;
    - with M_TREADY held high, one beat per cycle, DEPTH beats in DEPTH consecutive cycles.
  - Standard valid/ready rules:
    - M_TDATA and M_TLAST stay stable while M_TVALID = 1 and M_TREADY = 0;
    - M_TVALID never deasserts without a handshake;
    - no beat is dropped or duplicated under arbitrary M_TREADY toggling.
  - M_TLAST = 1 only on beat DEPTH-1.
  - Handshake of the last beat -> IDLE next cycle, with DONE_OUT = 1 for that one cycle.
  - Upstream samples arriving in READOUT are discarded.
  - ARM_IN in READOUT: aborts replay, M_TVALID = 0 next cycle, state -> ARMED, no DONE_OUT.
- STATE_OUT is registered and equals the encoded current state.

Decomposition:
- Package pdm_capture_pkg:
  - state encoding localparams ST_IDLE, ST_ARMED, ST_CAPTURE, ST_READOUT;
  - default DATA_W and DEPTH.
- Sub-module pdm_capture_ram:
  - simple dual-port RAM, one write port, one synchronous-read port;
  - inferable as BRAM, no reset on the data array.
- FSM, counters and output skid stage live in pdm_capture_buffer.

Test Plan:
- DEPTH = 8, THRESHOLD = 40, ARM, then samples 10, 20, 50, 60..65 with M_TREADY = 1 -> trigger on 50; replay 50, 60, 61..65, 66 (ramp extended to 8 samples); M_TLAST on beat 8; DONE_OUT one cycle after it; STATE_OUT back to 0.
- ARM then FORCE_TRIG with all samples at 0 -> capture of 8 zeros starting at the next valid sample; first M_TVALID exactly 2 cycles after STATE_OUT = 3.
- Replay with M_TREADY pseudo-random (50%) -> exactly 8 beats, in order, M_TDATA stable while stalled, no gaps counted as beats.
- ARM during READOUT after 3 beats -> M_TVALID low next cycle, STATE_OUT = 1, no DONE_OUT; a new trigger replays fresh data.
- RST_IN asserted mid-CAPTURE (after 4 writes) -> outputs 0 immediately; after release, ARM plus trigger captures a full new burst with no stale count.
- Samples with AMP_VALID_IN = 0 during ARMED whose AMP_IN exceeds the threshold -> no trigger.
